// File: rtl/uart_rx_16x.sv
// 16x-oversampling UART receiver: 7 data bits, even parity, 1 stop bit.
// Each bit is the majority of three mid-bit samples; the completed frame sits in a valid/ready holding register.
module uart_rx_16x #(
  parameter int TICK_DIV = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [6:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    samp_q, samp_d;
  logic          s7_q, s7_d, s8_q, s8_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [6:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [6:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  logic tick, decide, last, bit_val, done, free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      div_q     <= '0;
      samp_q    <= '0;
      s7_q      <= 1'b0;
      s8_q      <= 1'b0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      div_q     <= div_d;
      samp_q    <= samp_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    samp_d    = samp_q;
    s7_d      = s7_q;
    s8_d      = s8_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = 1'b0;
    done      = 1'b0;

    tick    = (div_q == DW'(TICK_DIV - 1));
    decide  = tick && (samp_q == 4'd9);
    last    = tick && (samp_q == 4'd15);
    // Samples at counts 7 and 8 are stored; the count-9 sample is the live line.
    bit_val = (s7_q & s8_q) | (s7_q & sync2_q) | (s8_q & sync2_q);
    free    = !valid_q || rx_ready;

    if (state_q == IDLE) begin
      div_d     = '0;
      samp_d    = '0;
      bit_idx_d = '0;
      if (prev_q && !sync2_q) state_d = START;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) samp_d = samp_q + 4'd1;
      if (tick && samp_q == 4'd7) s7_d = sync2_q;
      if (tick && samp_q == 4'd8) s8_d = sync2_q;
    end

    case (state_q)
      START: begin
        if (decide && bit_val) state_d = IDLE;
        else if (last)         state_d = DATA;
      end
      DATA: begin
        if (decide) shift_d = {bit_val, shift_q[6:1]};
        if (last) begin
          if (bit_idx_q == 3'd6) state_d = PARITY;
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (decide) par_d = bit_val;
        if (last)   state_d = STOP;
      end
      STOP: begin
        if (decide) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (done && free) begin
      data_d  = shift_q;
      perr_d  = ^{shift_q, par_q};
      ferr_d  = !bit_val;
      valid_d = 1'b1;
    end else if (done) begin
      ovr_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_16x.sv
// Bench for uart_rx_16x: serial driver pushes expected frames, a negedge monitor pops and compares.
module tb_uart_rx_16x;

  localparam int TD      = 4;
  localparam int BIT     = 16 * TD;
  localparam int LAT_NOM = (9 * 16 + 10) * TD + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b1;
  logic [6:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;
  logic [2:0] state_dbg;

  uart_rx_16x #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;
  // {fall_cycle[31:0], parity_err, frame_err, data[6:0]}
  logic [40:0] exp_q[$];
  int ovr_cnt = 0;
  int last_ovr_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic check_window(input string name, input int act, input int nom);
    n_cmp++;
    if (act < nom - TD || act > nom + TD) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d +/- %0d", name, act, nom, TD);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [6:0] d, input logic p, input logic s);
    exp_q.push_back({cyc, ^{d, p}, ~s, d});
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    idle(BIT);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic p, input logic s, input bit deliver);
    if (deliver) push_exp(d, p, s);
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  // Monitor: a frame is presented when rx_valid is seen after idle or after a handshake.
  logic       prev_valid = 1'b0, prev_hs = 1'b0, prev_ovr = 1'b0;
  logic [8:0] held = '0;
  always @(negedge clk) begin
    logic [40:0] e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_ovr   = 1'b0;
    end else begin
      if (rx_valid && (!prev_valid || prev_hs)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: got rx_valid=1 data %0h want no frame", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e[6:0]));
          check("frame_err", 32'(frame_err), 32'(e[7]));
          check("parity_err", 32'(parity_err), 32'(e[8]));
          check_window("latency", int'(cyc) - int'(e[40:9]), LAT_NOM);
        end
        held = {parity_err, frame_err, rx_data};
      end else if (rx_valid) begin
        check("held_stable", 32'({parity_err, frame_err, rx_data}), 32'(held));
      end
      if (overrun) begin
        ovr_cnt++;
        last_ovr_cyc = int'(cyc);
        if (prev_ovr) begin
          n_cmp++;
          n_err++;
          $display("FAIL overrun_width: got 2+ cycles want 1 cycle");
        end
      end
      prev_valid = rx_valid;
      prev_hs    = rx_valid && rx_ready;
      prev_ovr   = overrun;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got no finish want finish within 80000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] d;
    logic       p;
    int         gap;
    bit         seen;
    int         ovr_before;
    int         f2;

    rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b1;
    idle(3);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(20);

    send_frame(7'h55, 1'b0, 1'b1, 1'b1);
    idle(30);
    send_frame(7'h07, 1'b0, 1'b1, 1'b1);
    idle(30);
    send_frame(7'h07, 1'b1, 1'b1, 1'b1);
    idle(30);

    // Bad stop bit, then the line stays low: exactly one frame.
    send_frame(7'h2A, 1'b1, 1'b0, 1'b1);
    idle(1000);
    rx_in = 1'b1;
    idle(100);
    send_frame(7'h11, 1'b0, 1'b1, 1'b1);
    idle(30);

    // Short low glitch: busy must rise, then fall with no frame.
    rx_in = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (busy) seen = 1'b1;
    end
    rx_in = 1'b1;
    check("glitch_busy_rise", 32'(seen), 32'd1);
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      idle(1);
    end
    check("glitch_busy_fall", 32'(busy), 32'd0);
    idle(700);

    // Break from idle.
    push_exp(7'h00, 1'b0, 1'b0);
    rx_in = 1'b0;
    idle(1000);
    rx_in = 1'b1;
    idle(100);

    // Overrun: consumer stalled, two back-to-back frames.
    rx_ready = 1'b0;
    ovr_before = ovr_cnt;
    send_frame(7'h12, ^7'h12, 1'b1, 1'b1);
    f2 = int'(cyc);
    send_frame(7'h34, ^7'h34, 1'b1, 1'b0);
    idle(20);
    check("overrun_count", 32'(ovr_cnt - ovr_before), 32'd1);
    check_window("overrun_time", last_ovr_cyc - f2, LAT_NOM);
    check("held_valid", 32'(rx_valid), 32'd1);
    check("held_data", 32'(rx_data), 32'h12);
    rx_ready = 1'b1;
    idle(1);
    check("valid_clear", 32'(rx_valid), 32'd0);
    idle(30);

    // Reset during d3 of a frame.
    d = 7'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx_in = d[3];
    idle(10);
    rst = 1'b1;
    rx_in = 1'b1;
    idle(10);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    idle(700);
    check("postrst_busy", 32'(busy), 32'd0);
    send_frame(7'h7F, 1'b1, 1'b1, 1'b1);
    idle(30);

    // Random frames with random gaps (including back-to-back).
    for (int n = 0; n < 10; n++) begin
      d   = 7'($urandom_range(0, 127));
      p   = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 40));
      send_frame(d, p, 1'b1, 1'b1);
      idle(gap);
    end
    idle(700);
    check("pending_frames", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_16x.md
UART_RX_16X -- requirements
Module: uart_rx_16x

Interface
REQ-001 SHALL have parameter TICK_DIV, default 33, meaning clk cycles per 16x oversample tick (10 MHz / (19200*16)); legal values >= 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rx_in, input, 1, asynchronous serial line, idle high.
REQ-005 SHALL have port rx_data, output, 7, received data bits d6..d0.
REQ-006 SHALL have port rx_valid, output, 1, rx_data and error flags hold a frame.
REQ-007 SHALL have port rx_ready, input, 1, consumer accepts the frame when rx_valid=1.
REQ-008 SHALL have port parity_err, output, 1, even-parity mismatch on the held frame.
REQ-009 SHALL have port frame_err, output, 1, stop bit sampled low on the held frame.
REQ-010 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer; both flops reset to 1.
REQ-013 SHALL decode the frame: start(0), d0..d6 LSB first, parity, stop(1), with even parity so that XOR(d0..d6, parity) = 0.
REQ-014 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 In IDLE, the tick divider and sample counter SHALL be held at 0, and a 1->0 transition of the synchronized line SHALL move the FSM to START.
REQ-016 In non-IDLE states, a tick SHALL occur every TICK_DIV clocks, and a 4-bit sample counter SHALL increment per tick, wrapping 15->0.
REQ-017 Each bit value SHALL be the majority of the synchronized samples taken at sample counts 7, 8 and 9, and SHALL be decided on the count-9 tick.
REQ-018 In START, a decided value of 1 SHALL return the FSM to IDLE (false start), with no output change.
REQ-019 On the count-15 tick, START SHALL go to DATA, DATA (after the 7th bit, 3-bit index) SHALL go to PARITY, and PARITY SHALL go to STOP.
REQ-020 In STOP, on the count-9 decision, the frame SHALL complete and the FSM SHALL go to IDLE in the same cycle, so back-to-back frames are received.
REQ-021 On completion with the holding register free (rx_valid=0, or rx_valid&rx_ready in that same cycle), the block SHALL load rx_data, parity_err and frame_err, and set rx_valid=1 in the next cycle.
REQ-022 On completion with rx_valid=1 and rx_ready=0, the held frame SHALL be kept unchanged, the new frame discarded, and overrun pulsed high for exactly 1 cycle.
REQ-023 rx_valid SHALL clear on the cycle after rx_valid&rx_ready unless a reload per REQ-021 coincides.
REQ-024 rx_data, parity_err and frame_err SHALL remain stable while rx_valid=1.
REQ-025 A frame with frame_err=1 SHALL still be delivered.
REQ-026 After a frame_err, a new start SHALL require the line to return high first; a held-low line (break) SHALL produce no further frames.
REQ-027 A low pulse shorter than about 8 ticks SHALL be rejected per REQ-018.
REQ-028 Latency from the rx_in falling edge to rx_valid rise SHALL be (9*16+10)*TICK_DIV + 4 clocks, +/- TICK_DIV.

Reset
REQ-029 While rst=1, the block SHALL hold: FSM=IDLE; counters=0; synchronizer=1; rx_data=0; rx_valid=0; parity_err=0; frame_err=0; overrun=0; busy=0.
REQ-030 Reset mid-frame SHALL abort the frame with no rx_valid.
REQ-031 After reset release, a start bit SHALL be accepted only after a 1->0 edge on the synchronized line.

Verification (TICK_DIV=4, bit=64 clocks)
REQ-032 Frame 7'h55 with parity 0, stop 1, rx_ready=1 -> rx_valid 1 cycle, rx_data=7'h55, parity_err=0, frame_err=0, latency per REQ-028.
REQ-033 Frame 7'h07 with parity 0 -> rx_data=7'h07, parity_err=1; then frame 7'h07 with parity 1 -> parity_err=0.
REQ-034 Frame 7'h2A with stop=0, then line held low for 1000 clocks -> one frame with frame_err=1, no further rx_valid; line high then frame 7'h11 -> rx_data=7'h11.
REQ-035 rx_in low pulse of 20 clocks -> busy rises then falls, no rx_valid; rx_in low for 1000 clocks from idle (break) -> one frame, rx_data=0, parity_err=0, frame_err=1.
REQ-036 rx_ready=0 and back-to-back frames 7'h12 then 7'h34 -> rx_data=7'h12 held, overrun pulses 1 cycle at the end of the 2nd frame; rx_ready=1 -> rx_valid clears next cycle.
REQ-037 rst asserted at d3 of a frame, released 10 clocks later, then frame 7'h7F with parity 1 -> no output from the aborted frame, then rx_data=7'h7F, parity_err=0.
